if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch stage: owns the fetch PC, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small in-order queue. It sits directly upstream of the IF/ID register that feeds `id`, consuming `id`'s `branch_flag_o`/`branch_target_address_o` as a redirect and the pipeline stall as back-pressure. When no instruction is available, it presents a NOP.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `QUEUE_DEPTH`, default 2: instruction queue entries; legal values 2 or 4.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `stall_i` input 1: downstream stall; head entry is held, not consumed.
- `branch_flag_i` input 1: redirect request from decode.
- `branch_target_address_i` input 32: redirect target.
- `mem_req_o` output 1: read request valid.
- `mem_addr_o` output 32: read address; stable while `mem_req_o`=1 and `mem_gnt_i`=0.
- `mem_gnt_i` input 1: request accepted this cycle.
- `mem_rvalid_i` input 1: read data valid; at most one response per grant, in order.
- `mem_rdata_i` input 32: instruction word.
- `inst_valid_o` output 1: queue head valid.
- `inst_o` output 32: head instruction; 32'h0000_0013 when `inst_valid_o`=0.
- `pc_o` output 32: head PC; 32'h0 when `inst_valid_o`=0.
- `misalign_o` output 1: misaligned-target flag (only with `FETCH_MISALIGN_CHECK_EN`).

## Operation
- Registers:
  - fetch PC `fpc`.
  - Queue of {pc, inst}, QUEUE_DEPTH entries, with wrapping read/write pointers and a count.
  - One-bit `drop` flag.
  - FSM with states IDLE, REQ, WAIT.
- At most one request outstanding. An issue is allowed when count + (state≠IDLE) < QUEUE_DEPTH.
- IDLE: if an issue is allowed and there is no redirect, go to REQ.
- REQ: `mem_req_o`=1, `mem_addr_o`=`fpc`. On `mem_gnt_i`: latch the issued pc, set `fpc`←`fpc`+4 (32-bit wrap), go to WAIT.
- WAIT: on `mem_rvalid_i`:
  - If `drop`=0 and there is no redirect this cycle, enqueue {issued pc, `mem_rdata_i`}. Otherwise discard the response.
  - Clear `drop`.
  - Go to REQ if a further issue is allowed, else IDLE.
- Dequeue when `inst_valid_o`=1, `stall_i`=0 and `branch_flag_i`=0.
- Redirect (`branch_flag_i`=1) has priority over everything else:
  - The queue is flushed (count←0).
  - `fpc`←target.
  - If in WAIT without `rvalid`, set `drop`.
  - If in REQ, the request stays asserted with its old address until granted, then enters WAIT with `drop`=1. `fpc` then holds the target, not the old address+4.
- Enqueue and dequeue in the same cycle are legal at any count; the count is unchanged.
- A queue overflow cannot occur because space is reserved at issue.
- Reset mid-operation clears the FSM to IDLE, `drop` to 0 and the queue to empty. Any outstanding memory transaction is abandoned; the memory model must be reset together with this block.

## Timing
- Reset values:
  - `mem_req_o`=0, `mem_addr_o`=RESET_PC.
  - `inst_valid_o`=0, `inst_o`=32'h0000_0013, `pc_o`=0.
  - `misalign_o`=0.
  - `fpc`=RESET_PC.
- The first `mem_req_o` is asserted in the first cycle after `rst` deasserts.
- Latency: with a grant in cycle n and `rvalid` in n+1, `inst_valid_o` rises in n+2. There is no bypass from `mem_rdata_i` to `inst_o`.
- Peak throughput: one instruction per 2 cycles. WAIT→REQ happens on the `rvalid` edge.
- After a redirect in cycle n: `inst_valid_o`=0 in n+1. The earliest request to the target is in n+1, or after the pending grant/response has drained.
- `inst_o`/`pc_o` are combinational from the queue head. `mem_*` outputs come from registers or state only.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with target[1:0]≠0 flushes the queue, sets `misalign_o`=1 (sticky) and holds the FSM in IDLE.
  - `misalign_o` clears only on an aligned redirect or on reset.
- Not defined:
  - The `misalign_o` port is absent.
  - `fpc` takes {target[31:2], 2'b00}.
  - Fetch never halts.

## Test plan
- Reset release, memory with zero-wait grant and 1-cycle `rvalid`, words at 0x0/0x4/0x8 → `pc_o` sequence 0x0, 0x4, 0x8. First `inst_valid_o` 2 cycles after the first request.
- `stall_i` held high for 10 cycles → queue fills to QUEUE_DEPTH, `mem_req_o` stays 0, head `pc_o` unchanged. On release, the entries drain in order.
- Redirect to 0x100 while in WAIT, with `rvalid` 3 cycles later → the stale word is discarded and the next valid `pc_o`=0x100.
- Redirect to 0x200 while `mem_req_o` is pending with no grant → `mem_addr_o` is held at the old address until granted, that response is dropped, then a request to 0x200 is issued.
- `rst` asserted mid-WAIT → all outputs return to reset values immediately (asynchronous), and fetch restarts at RESET_PC.
- Redirect to 0x102 → with the macro: `misalign_o`=1 and no requests. Without the macro: the next request goes to 0x100.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage.
// Owns the fetch PC and issues one word read at a time over a req/gnt/rvalid
// handshake. Returned words go into a small in-order queue that feeds the
// IF/ID register. A redirect from decode flushes the queue, retargets the
// fetch PC and discards any in-flight response.
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to flag misaligned redirect
// targets on a sticky misalign_o and halt fetch until an aligned redirect.
//
// Ports:
//   clk, rst (async, active-low)
//   stall_i                  downstream stall, holds the queue head
//   branch_flag_i            redirect request
//   branch_target_address_i  redirect target
//   mem_req_o/mem_addr_o     read request and address
//   mem_gnt_i                request accepted
//   mem_rvalid_i/mem_rdata_i read response
//   inst_valid_o/inst_o/pc_o queue head (NOP and pc 0 when empty)
//   misalign_o               misaligned redirect flag (macro only)
module if_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_address_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        misalign_o
`endif
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       fpc_q, fpc_d;
   logic [31:0]       addr_q, addr_d;
   logic              drop_q, drop_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       q_pc_q   [QUEUE_DEPTH];
   logic [31:0]       q_inst_q [QUEUE_DEPTH];

   logic              redirect;
   logic [31:0]       target_word;
   logic              enq;
   logic              deq;
   logic              halt;
   logic              issue_ok;

   assign redirect    = branch_flag_i;
   assign target_word = branch_target_address_i & 32'hFFFF_FFFC;

   // Sticky misalignment flag; while set (or being set) no new fetch is issued.
`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   always_comb begin
      misalign_d = misalign_q;
      if (redirect) begin
         misalign_d = |branch_target_address_i[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign halt       = misalign_d;
   assign misalign_o = misalign_q;
`else
   assign halt = 1'b0;
`endif

   // Response is kept only if it was not already marked stale and no redirect hits now.
   assign enq = (state_q == WAIT) && mem_rvalid_i && !drop_q && !redirect;
   assign deq = (count_q != '0) && !stall_i && !redirect;

   // Queue bookkeeping; a redirect empties the queue and rewinds both pointers.
   always_comb begin
      count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
      rd_ptr_d = rd_ptr_q + PTR_W'(deq);
      wr_ptr_d = wr_ptr_q + PTR_W'(enq);
      if (redirect) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
   end

   // Space for the response is reserved when the request is issued.
   assign issue_ok = (count_d < DEPTH_CNT) && !halt;

   // Fetch FSM: next state, fetch PC, request address and drop flag.
   always_comb begin
      state_d = state_q;
      fpc_d   = redirect ? target_word : fpc_q;
      addr_d  = addr_q;
      drop_d  = drop_q;
      unique case (state_q)
         IDLE: begin
            if (issue_ok && !redirect) begin
               state_d = REQ;
               addr_d  = fpc_q;
            end
         end
         REQ: begin
            // The request cannot be withdrawn; a redirect only marks its response stale.
            if (redirect) begin
               drop_d = 1'b1;
            end
            if (mem_gnt_i) begin
               state_d = WAIT;
               // drop_q here means fpc_q already holds a redirect target.
               if (!redirect && !drop_q) begin
                  fpc_d = fpc_q + 32'd4;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               drop_d = 1'b0;
               if (issue_ok) begin
                  state_d = REQ;
                  addr_d  = fpc_d;
               end else begin
                  state_d = IDLE;
               end
            end else if (redirect) begin
               drop_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         fpc_q    <= RESET_PC;
         addr_q   <= RESET_PC;
         drop_q   <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         fpc_q    <= fpc_d;
         addr_q   <= addr_d;
         drop_q   <= drop_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage; addr_q still holds the issued pc while in WAIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_pc_q   <= '{default: '0};
         q_inst_q <= '{default: '0};
      end else if (enq) begin
         q_pc_q[wr_ptr_q]   <= addr_q;
         q_inst_q[wr_ptr_q] <= mem_rdata_i;
      end
   end

   assign mem_req_o    = (state_q == REQ);
   assign mem_addr_o   = addr_q;
   assign inst_valid_o = (count_q != '0);
   assign inst_o       = inst_valid_o ? q_inst_q[rd_ptr_q] : NOP;
   assign pc_o         = inst_valid_o ? q_pc_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a memory model answers requests, a scoreboard holds the
// expected {pc, inst} stream and a monitor checks every dequeued head entry.
module tb_if_fetch;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_o;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   popped = 0;

   // Memory model controls
   bit   gnt_en = 1'b1;
   int   rvalid_delay = 1;

   if_fetch #(
      .RESET_PC    (32'h0000_0000),
      .QUEUE_DEPTH (2)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall_i                 (stall_i),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .mem_req_o               (mem_req_o),
      .mem_addr_o              (mem_addr_o),
      .mem_gnt_i               (mem_gnt_i),
      .mem_rvalid_i            (mem_rvalid_i),
      .mem_rdata_i             (mem_rdata_i),
      .inst_valid_o            (inst_valid_o),
      .inst_o                  (inst_o),
      .pc_o                    (pc_o)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .misalign_o              (misalign_o)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA500_0000 | {8'h00, a[23:0]};
   endfunction

   // Memory: grants at once when enabled, answers rvalid_delay cycles after the grant.
   initial begin
      bit          pend;
      int          resp_wait;
      logic [31:0] pend_addr;
      pend = 1'b0;
      resp_wait = 0;
      pend_addr = '0;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         mem_gnt_i = 1'b0;
         mem_rvalid_i = 1'b0;
         mem_rdata_i = '0;
         if (!rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               resp_wait--;
               if (resp_wait <= 0) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i = mem_word(pend_addr);
                  pend = 1'b0;
               end
            end
            if (mem_req_o && gnt_en) begin
               mem_gnt_i = 1'b1;
               pend = 1'b1;
               pend_addr = mem_addr_o;
               resp_wait = rvalid_delay;
            end
         end
      end
   end

   // Monitor: every consumed head entry must match the next expected one.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && inst_valid_o && !stall_i && !branch_flag_i) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL deq_unexpected: got pc=%h inst=%h, required no dequeue", pc_o, inst_o);
            end else begin
               e = sb.pop_front();
               if (pc_o !== e.pc || inst_o !== e.inst) begin
                  errors++;
                  $display("FAIL deq_order: got pc=%h inst=%h, required pc=%h inst=%h",
                           pc_o, inst_o, e.pc, e.inst);
               end
            end
            popped++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc = pc;
      e.inst = inst;
      sb.push_back(e);
   endtask

   task automatic wait_req(input string name);
      int cyc = 0;
      while (!mem_req_o && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++;
      if (!mem_req_o) begin
         errors++;
         $display("FAIL %s: got mem_req_o=0 for 40 cycles, required a request", name);
      end
   endtask

   task automatic consume(input string name, input int n);
      int goal = popped + n;
      int cyc = 0;
      stall_i = 1'b0;
      while (popped < goal && cyc < 60) begin
         tick();
         cyc++;
      end
      stall_i = 1'b1;
      checks++;
      if (popped < goal) begin
         errors++;
         $display("FAIL %s: got %0d dequeues, required %0d", name, popped - (goal - n), n);
      end
   endtask

   task automatic redirect(input logic [31:0] tgt);
      branch_flag_i = 1'b1;
      branch_target_address_i = tgt;
      tick();
      branch_flag_i = 1'b0;
      branch_target_address_i = '0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   32'(mem_req_o), 32'h0);
      chk({tag, "_addr"},  mem_addr_o, 32'h0);
      chk({tag, "_valid"}, 32'(inst_valid_o), 32'h0);
      chk({tag, "_inst"},  inst_o, 32'h0000_0013);
      chk({tag, "_pc"},    pc_o, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      stall_i = 1'b1;
      branch_flag_i = 1'b0;
      branch_target_address_i = '0;
      #1 rst = 1'b0;
      #2;
      chk_reset_vals("reset");
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("reset_misalign", 32'(misalign_o), 32'h0);
`endif
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;

      // First request, latency, no bypass
      tick();
      chk("first_req", 32'(mem_req_o), 32'h1);
      chk("first_addr", mem_addr_o, 32'h0);
      tick();
      chk("no_bypass_valid", 32'(inst_valid_o), 32'h0);
      tick();
      chk("latency_valid", 32'(inst_valid_o), 32'h1);
      chk("latency_pc", pc_o, 32'h0);
      chk("latency_inst", inst_o, 32'hA500_0000);
      chk("second_addr", mem_addr_o, 32'h4);

      // Stall held: queue fills to two entries and fetch stops
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("stall_no_req", 32'(mem_req_o), 32'h0);
         chk("stall_head_pc", pc_o, 32'h0);
         tick();
      end
      push(32'h0, 32'hA500_0000);
      push(32'h4, 32'hA500_0004);
      push(32'h8, 32'hA500_0008);
      consume("drain_in_order", 3);

      // Redirect to 0x100 while a response is outstanding (rvalid 3 cycles after grant)
      repeat (8) tick();
      chk("pre_redirect_valid", 32'(inst_valid_o), 32'h1);
      rvalid_delay = 3;
      redirect(32'h40);
      chk("flush_valid", 32'(inst_valid_o), 32'h0);
      chk("flush_inst_nop", inst_o, 32'h0000_0013);
      chk("flush_pc_zero", pc_o, 32'h0);
      wait_req("req_0x40");
      chk("addr_0x40", mem_addr_o, 32'h40);
      tick();
      redirect(32'h100);
      chk("wait_flush_valid", 32'(inst_valid_o), 32'h0);
      push(32'h100, 32'hA500_0100);
      wait_req("req_0x100");
      chk("addr_0x100", mem_addr_o, 32'h100);
      consume("stale_dropped", 1);

      // Asynchronous reset in WAIT with a valid head entry
      rvalid_delay = 1;
      repeat (12) tick();
      redirect(32'h300);
      wait_req("req_0x300");
      chk("addr_0x300", mem_addr_o, 32'h300);
      tick();
      rvalid_delay = 6;
      tick();
      chk("req_0x304", 32'(mem_req_o), 32'h1);
      chk("addr_0x304", mem_addr_o, 32'h304);
      tick();
      chk("pre_rst_valid", 32'(inst_valid_o), 32'h1);
      chk("pre_rst_pc", pc_o, 32'h300);
      rst = 1'b0;
      #1;
      chk_reset_vals("async_rst");

      // Restart at RESET_PC, then redirect while the request waits for a grant
      rvalid_delay = 1;
      gnt_en = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("restart_req", 32'(mem_req_o), 32'h1);
      chk("restart_addr", mem_addr_o, 32'h0);
      tick();
      redirect(32'h200);
      chk("held_req", 32'(mem_req_o), 32'h1);
      chk("held_addr", mem_addr_o, 32'h0);
      gnt_en = 1'b1;
      tick();
      push(32'h200, 32'hA500_0200);
      wait_req("req_0x200");
      chk("addr_0x200", mem_addr_o, 32'h200);
      consume("held_resp_dropped", 1);

      // Misaligned redirect target 0x102
      repeat (6) tick();
      redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
      repeat (4) tick();
      chk("misalign_set", 32'(misalign_o), 32'h1);
      for (int i = 0; i < 10; i++) begin
         chk("misalign_no_req", 32'(mem_req_o), 32'h0);
         tick();
      end
`else
      push(32'h100, 32'hA500_0100);
      wait_req("req_0x100_aligned");
      chk("addr_0x100_aligned", mem_addr_o, 32'h100);
      consume("aligned_fetch", 1);
`endif

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
